// File: rtl/fft_output_serializer.sv
// Captures a 16-bin FFT frame on the rising edge of fft_done and streams it out one bin per valid/ready beat.
// Optional build macro DIGIT_REVERSE_EN reads radix-4 digit-reversed slots back in natural bin order.
module fft_output_serializer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fft_done,
   input  logic [WIDTH*16-1:0]   fft_data_real,
   input  logic [WIDTH*16-1:0]   fft_data_imag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_real,
   output logic [WIDTH-1:0]      out_imag,
   output logic [3:0]            out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  overrun,
   input  logic                  clr_overrun,
   output logic [CNT_W-1:0]      frame_count
);

   localparam int N = 16;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_done_d;
   logic [3:0]           r_cnt;
   logic [3:0]           w_cnt_nxt;
   logic [WIDTH*N-1:0]   r_frame_re;
   logic [WIDTH*N-1:0]   r_frame_im;
   logic                 r_overrun;
   logic [CNT_W-1:0]     r_frame_count;
   logic                 w_done_edge;
   logic                 w_stream;
   logic                 w_capture;
   logic                 w_frame_end;
   logic                 w_drop;
   logic [3:0]           w_slot;

   assign w_done_edge = fft_done & ~r_done_d;
   assign w_stream    = (r_state == S_STREAM);

`ifdef DIGIT_REVERSE_EN
   assign w_slot = {r_cnt[1:0], r_cnt[3:2]};
`else
   assign w_slot = r_cnt;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= 4'd0;
         r_done_d      <= 1'b0;
         r_overrun     <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_done_d <= fft_done;
         if (w_drop)
            r_overrun <= 1'b1;
         else if (clr_overrun)
            r_overrun <= 1'b0;
         if (w_frame_end)
            r_frame_count <= r_frame_count + 1'b1;
      end
   end

   // Frame storage needs no reset: it is only observed while streaming.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_frame_re <= fft_data_real;
         r_frame_im <= fft_data_imag;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_frame_end = 1'b0;
      w_drop      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_done_edge) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = 4'd0;
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (out_ready && r_cnt == 4'd15) begin
               w_frame_end = 1'b1;
               w_cnt_nxt   = 4'd0;
               if (w_done_edge)
                  w_capture = 1'b1;
               else
                  w_state_nxt = S_IDLE;
            end else begin
               if (out_ready)
                  w_cnt_nxt = r_cnt + 4'd1;
               if (w_done_edge)
                  w_drop = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign out_valid   = w_stream;
   assign busy        = w_stream;
   assign out_real    = w_stream ? r_frame_re[WIDTH*w_slot +: WIDTH] : '0;
   assign out_imag    = w_stream ? r_frame_im[WIDTH*w_slot +: WIDTH] : '0;
   assign out_index   = w_stream ? r_cnt : 4'd0;
   assign out_last    = w_stream && (r_cnt == 4'd15);
   assign overrun     = r_overrun;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_fft_output_serializer.sv
// Bench for fft_output_serializer: queue-of-beats reference model, directed scenarios and random traffic.
// Build with DIGIT_REVERSE_EN defined to check the reordering build.
module tb_fft_output_serializer;

   localparam int W = 16;
   localparam int N = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            fft_done = 1'b0;
   logic            out_ready = 1'b0;
   logic            clr_overrun = 1'b0;
   logic [W*N-1:0]  re_bus = '0;
   logic [W*N-1:0]  im_bus = '0;
   logic            out_valid;
   logic [W-1:0]    out_real;
   logic [W-1:0]    out_imag;
   logic [3:0]      out_index;
   logic            out_last;
   logic            busy;
   logic            overrun;
   logic [7:0]      frame_count;

   fft_output_serializer #(.WIDTH(W), .CNT_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .fft_done(fft_done),
      .fft_data_real(re_bus),
      .fft_data_imag(im_bus),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_real(out_real),
      .out_imag(out_imag),
      .out_index(out_index),
      .out_last(out_last),
      .busy(busy),
      .overrun(overrun),
      .clr_overrun(clr_overrun),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic [3:0]   idx;
   } beat_t;

   // Model: pending beats of the frame being streamed, head = beat on the bus.
   beat_t        q[$];
   logic         m_ovr = 1'b0;
   logic [7:0]   m_fc = '0;
   logic         m_dprev = 1'b0;
   logic [W-1:0] cap_re[0:4095];
   logic [W-1:0] cap_im[0:4095];
   int           ncap = 0;

   int  n_err = 0;
   int  n_chk = 0;
   bit  chk_en = 1'b0;

   function automatic int slot(int k);
`ifdef DIGIT_REVERSE_EN
      return (k % 4) * 4 + k / 4;
`else
      return k;
`endif
   endfunction

   always @(posedge clk) begin
      beat_t b;
      bit    e;
      if (!rst_n) begin
         q.delete();
         m_ovr   = 1'b0;
         m_fc    = '0;
         m_dprev = 1'b0;
      end else begin
         e = fft_done && !m_dprev;
         if (q.size() != 0 && out_ready) begin
            if (ncap < 4096) begin
               cap_re[ncap] = out_real;
               cap_im[ncap] = out_imag;
            end
            ncap++;
            void'(q.pop_front());
            if (q.size() == 0)
               m_fc = m_fc + 8'd1;
         end
         if (e) begin
            if (q.size() == 0) begin
               for (int k = 0; k < N; k++) begin
                  b.re  = re_bus[W*slot(k) +: W];
                  b.im  = im_bus[W*slot(k) +: W];
                  b.idx = 4'(k);
                  q.push_back(b);
               end
               if (clr_overrun)
                  m_ovr = 1'b0;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (clr_overrun) begin
            m_ovr = 1'b0;
         end
         m_dprev = fft_done;
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (chk_en) begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("busy", 32'(busy), 32'(q.size() != 0));
         chk("overrun", 32'(overrun), 32'(m_ovr));
         chk("frame_count", 32'(frame_count), 32'(m_fc));
         if (q.size() != 0) begin
            chk("out_real", 32'(out_real), 32'(q[0].re));
            chk("out_imag", 32'(out_imag), 32'(q[0].im));
            chk("out_index", 32'(out_index), 32'(q[0].idx));
            chk("out_last", 32'(out_last), 32'(q[0].idx == 4'd15));
         end else begin
            chk("out_last_idle", 32'(out_last), 32'd0);
         end
      end
   endtask

   task automatic set_frame(int rbase, int ibase);
      for (int i = 0; i < N; i++) begin
         re_bus[W*i +: W] = 16'(rbase + i);
         im_bus[W*i +: W] = 16'(ibase - i);
      end
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      fft_done    = 1'b0;
      out_ready   = 1'b0;
      clr_overrun = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic pulse_done();
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
   endtask

   task automatic wait_q(int n, int lim, string nm);
      int k = 0;
      while (q.size() != n && k < lim) begin
         step();
         k++;
      end
      chk(nm, 32'(q.size()), 32'(n));
   endtask

   initial begin
      int base;

      do_reset();
      chk_en = 1'b1;
      step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_fc", 32'(frame_count), 32'd0);
      chk("rst_index", 32'(out_index), 32'd0);
      chk("rst_real", 32'(out_real), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);

      // Single frame, consumer always ready
      set_frame(100, 0);
      out_ready = 1'b1;
      base = ncap;
      pulse_done();
      chk("t1_first_idx", 32'(out_index), 32'd0);
      chk("t1_first_real", 32'(out_real), 32'd100);
      wait_q(0, 40, "t1_drain");
      step();
      chk("t1_beats", 32'(ncap - base), 32'd16);
`ifdef DIGIT_REVERSE_EN
      chk("t1_re1", 32'(cap_re[base+1]), 32'd104);
      chk("t1_re4", 32'(cap_re[base+4]), 32'd101);
      chk("t1_im1", 32'(cap_im[base+1]), 32'h0000fffc);
`else
      chk("t1_re1", 32'(cap_re[base+1]), 32'd101);
      chk("t1_re4", 32'(cap_re[base+4]), 32'd104);
      chk("t1_im1", 32'(cap_im[base+1]), 32'h0000ffff);
`endif
      chk("t1_re15", 32'(cap_re[base+15]), 32'd115);
      chk("t1_im15", 32'(cap_im[base+15]), 32'h0000fff1);
      chk("t1_fc", 32'(frame_count), 32'd1);
      chk("t1_ovr", 32'(overrun), 32'd0);
      chk("t1_idle", 32'(out_valid), 32'd0);

      // Alternating ready
      do_reset();
      set_frame(100, 0);
      out_ready = 1'b1;
      base = ncap;
      pulse_done();
      for (int k = 0; k < 80 && q.size() != 0; k++) begin
         out_ready = ~out_ready;
         step();
      end
      chk("t2_drain", 32'(q.size()), 32'd0);
      chk("t2_beats", 32'(ncap - base), 32'd16);
`ifdef DIGIT_REVERSE_EN
      chk("t2_re3", 32'(cap_re[base+3]), 32'd112);
`else
      chk("t2_re3", 32'(cap_re[base+3]), 32'd103);
`endif
      chk("t2_fc", 32'(frame_count), 32'd1);

      // Dropped frame during beat 5
      do_reset();
      set_frame(100, 0);
      out_ready = 1'b1;
      base = ncap;
      pulse_done();
      wait_q(11, 40, "t3_reach5");
      chk("t3_idx5", 32'(out_index), 32'd5);
      set_frame(500, -50);
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
      chk("t3_ovr_set", 32'(overrun), 32'd1);
      wait_q(0, 40, "t3_drain");
`ifdef DIGIT_REVERSE_EN
      chk("t3_re6", 32'(cap_re[base+6]), 32'd109);
`else
      chk("t3_re6", 32'(cap_re[base+6]), 32'd106);
`endif
      chk("t3_re15", 32'(cap_re[base+15]), 32'd115);
      chk("t3_valid", 32'(out_valid), 32'd0);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      chk("t3_ovr_clr", 32'(overrun), 32'd0);
      set_frame(100, 0);
      pulse_done();
      wait_q(8, 40, "t3_mid");
      fft_done    = 1'b1;
      clr_overrun = 1'b1;
      step();
      fft_done    = 1'b0;
      clr_overrun = 1'b0;
      chk("t3_set_wins", 32'(overrun), 32'd1);
      wait_q(0, 40, "t3_drain2");

      // Back-to-back on the final handshake
      do_reset();
      set_frame(100, 0);
      out_ready = 1'b1;
      pulse_done();
      wait_q(1, 40, "t4_last");
      chk("t4_last_flag", 32'(out_last), 32'd1);
      set_frame(200, -20);
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_idx", 32'(out_index), 32'd0);
      chk("t4_real", 32'(out_real), 32'd200);
      chk("t4_imag", 32'(out_imag), 32'h0000ffec);
      chk("t4_ovr", 32'(overrun), 32'd0);
      wait_q(0, 40, "t4_drain");
      step();
      chk("t4_fc", 32'(frame_count), 32'd2);

      // Reset mid-stream with fft_done held across release
      do_reset();
      set_frame(100, 0);
      out_ready = 1'b1;
      pulse_done();
      wait_q(9, 40, "t5_reach7");
      chk("t5_idx7", 32'(out_index), 32'd7);
      rst_n    = 1'b0;
      fft_done = 1'b1;
      step();
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_fc", 32'(frame_count), 32'd0);
      rst_n = 1'b1;
      step();
      chk("t5_restart", 32'(out_valid), 32'd1);
      chk("t5_idx0", 32'(out_index), 32'd0);
      fft_done = 1'b0;
      wait_q(0, 40, "t5_drain");
      step();
      chk("t5_fc1", 32'(frame_count), 32'd1);

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst_n       = ($urandom_range(0, 299) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         clr_overrun = ($urandom_range(0, 15) == 0);
         fft_done    = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < N; i++) begin
            re_bus[W*i +: W] = 16'($urandom);
            im_bus[W*i +: W] = 16'($urandom);
         end
         step();
      end
      rst_n       = 1'b1;
      fft_done    = 1'b0;
      clr_overrun = 1'b0;
      out_ready   = 1'b1;
      wait_q(0, 40, "rnd_drain");
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fft_output_serializer.md
Name: fft_output_serializer

Overview:
- Downstream stage of fft_radix4_top.
- Captures the 16-bin parallel result (real/imag buses) when the FFT signals done.
- Streams the bins out one per handshake on a valid/ready interface with bin index and last flag, so parallel FFT results can feed serial consumers (magnitude unit, DMA, UART bridge).
- Flags frames dropped while a stream is in progress.

Parameters:
WIDTH  16  signed sample width per real/imag component (N = 16 bins fixed, localparam)
CNT_W  8   width of the completed-frame counter

Ports:
clk            input   1          system clock, all logic on rising edge
rst_n          input   1          synchronous active-low reset
fft_done       input   1          FFT done; a frame is offered on its rising edge
fft_data_real  input   WIDTH*16   FFT real outputs, bin slot i at [WIDTH*i +: WIDTH]
fft_data_imag  input   WIDTH*16   FFT imag outputs, same packing
out_valid      output  1          output beat valid
out_ready      input   1          consumer ready; beat transfers when out_valid && out_ready
out_real       output  WIDTH      signed real part of current bin
out_imag       output  WIDTH      signed imag part of current bin
out_index      output  4          bin index of current beat (0..15)
out_last       output  1          high on the beat with out_index == 15
busy           output  1          high while a frame is held or streaming
overrun        output  1          sticky: a done edge was dropped
clr_overrun    input   1          clears overrun
frame_count    output  CNT_W      number of fully streamed frames, wraps

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - out_valid, busy, overrun, out_last = 0.
  - out_index, out_real, out_imag, frame_count = 0.
  - Beat counter = 0; state = IDLE.
  - Done-delay register done_d = 0, so fft_done held high through reset release counts as an edge.
- Edge detect: done_edge = fft_done && !done_d; done_d registers fft_done every cycle.
- State IDLE:
  - out_valid = 0, busy = 0.
  - On done_edge: latch both buses into the frame register, beat counter = 0, go to STREAM.
  - Latency: edge sampled at edge t gives out_valid = 1 with index 0 after edge t (visible in cycle t+1).
- State STREAM:
  - out_valid = 1, busy = 1.
  - out_real/out_imag = frame[slot(cnt)], out_index = cnt, out_last = (cnt == 15).
  - While out_valid && !out_ready, all outputs hold stable.
  - Handshake with cnt < 15: cnt increments.
  - Handshake with cnt == 15: frame_count increments (wraps at 2^CNT_W), then
    - if done_edge in the same cycle: capture the new frame, cnt = 0, stay in STREAM (zero-bubble back-to-back, no overrun);
    - otherwise go to IDLE.
- Overrun: a done_edge in STREAM on any cycle other than a final handshake is ignored.
  - The frame register is not modified and the current stream continues unchanged.
  - overrun is set the next cycle.
- clr_overrun clears overrun; if a set event and clr_overrun coincide, set wins.
- Reset mid-stream discards the frame; out_valid = 0 after that edge; frame_count is not incremented.
- No arithmetic on data; samples pass bit-exact.
- slot(cnt) = cnt by default (see Optional Feature).
- The frame register is the only storage: 2*16*WIDTH flops.

Optional Feature:
- Macro DIGIT_REVERSE_EN.
- Defined: the serializer undoes radix-4 digit-reversed output ordering.
  - slot(cnt) = 4*cnt[1:0] + cnt[3:2].
  - out_index still reports the natural bin number cnt.
- Not defined: slot(cnt) = cnt, so bins go out in bus-slot order.
- Handshake and timing are identical in both builds.

Test Plan:
1. Slot i real = 100+i, imag = -i; out_ready = 1; one done pulse → 16 consecutive beats, out_real 100..115, out_imag 0..-15, out_index 0..15, out_last only on beat 15, then IDLE, frame_count = 1, overrun = 0.
2. Same frame, out_ready alternating 1/0 → outputs stable during every stall, exactly 16 transfers in order, busy high until the final handshake.
3. Second done edge during beat 5 with different data → stream still emits first-frame values 100..115; overrun = 1 one cycle later; clr_overrun pulse → overrun = 0; clr_overrun together with a new drop → overrun stays 1.
4. Done edge coincident with the final handshake → next cycle out_valid = 1, out_index = 0, new-frame data, no gap, overrun = 0, frame_count = 2 after both frames.
5. rst_n = 0 at beat 7 → out_valid = 0, busy = 0, frame_count = 0 after that edge; fft_done held high across release → new stream starts at index 0.
6. With DIGIT_REVERSE_EN, frame of test 1 → beats emit real 100,104,108,112,101,105,...,115 while out_index runs 0..15.
